dct_input_feeder: RTL and testbench

Upstream stage of the 16-point DCT. Accepts a serial stream of 8-bit samples in natural order (x[0]..x[15]) with a valid/ready handshake and buffers each 16-sample block in a ping-pong bank pair. For each full block it drives the DCT's `start`, `INPUT_A` and `INPUT_B` ports with the symmetric pair sequence (x[k], x[15-k]), k = 0..7, over eight consecutive cycles. It also enforces a minimum spacing between successive blocks.

---
 rtl/dct_input_feeder.sv | 143 ++++++++++++++
 tb/tb_dct_input_feeder.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_input_feeder.sv
// Input feeder for the 16-point DCT: buffers serial 8-bit samples into a ping-pong bank pair
// and drains each full block as eight symmetric (x[k], x[15-k]) pairs with a start pulse.
module dct_input_feeder #(
  parameter int unsigned BLOCK_GAP = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       start,
  output logic [7:0] INPUT_A,
  output logic [7:0] INPUT_B,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StDrain, StGap} state_e;

  // GAP releases to IDLE one cycle early so the IDLE->DRAIN edge lands BLOCK_GAP after start.
  localparam logic [7:0] GapExit = 8'(BLOCK_GAP - 2);

  logic [7:0] mem_q [32];

  state_e     state_q, state_d;
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [3:0] wr_cnt_q, wr_cnt_d;
  logic [2:0] beat_q, beat_d;
  logic [1:0] full_q, full_d;
  logic [1:0] full_set, full_clr;
  logic [7:0] gap_q, gap_d;
  logic       start_q, start_d;
  logic       busy_q, busy_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       accept;
  logic       load;

  assign in_ready = ~full_q[wr_bank_q];
  assign accept   = in_valid & in_ready;

  assign start   = start_q;
  assign INPUT_A = a_q;
  assign INPUT_B = b_q;
  assign busy    = busy_q;

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    full_set  = 2'b00;
    full_clr  = 2'b00;
    if (accept) begin
      wr_cnt_d = wr_cnt_q + 4'd1;
      if (wr_cnt_q == 4'd15) begin
        full_set[wr_bank_q] = 1'b1;
        wr_bank_d           = ~wr_bank_q;
      end
    end

    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    beat_d    = beat_q;
    gap_d     = (gap_q == 8'hFF) ? gap_q : gap_q + 8'd1;
    load      = 1'b0;
    case (state_q)
      StIdle: begin
        if (full_q[rd_bank_q]) begin
          state_d = StDrain;
          beat_d  = 3'd0;
          gap_d   = 8'd0;
          load    = 1'b1;
        end
      end
      StDrain: begin
        if (beat_q != 3'd7) begin
          beat_d = beat_q + 3'd1;
          load   = 1'b1;
        end else begin
          full_clr[rd_bank_q] = 1'b1;
          rd_bank_d           = ~rd_bank_q;
          beat_d              = 3'd0;
          // Only the minimum gap allows the next block to follow with no idle cycle.
          if (BLOCK_GAP <= 8 && full_q[~rd_bank_q]) begin
            state_d = StDrain;
            gap_d   = 8'd0;
            load    = 1'b1;
          end else if (BLOCK_GAP <= 9) begin
            state_d = StIdle;
          end else begin
            state_d = StGap;
          end
        end
      end
      StGap: begin
        if (gap_q >= GapExit) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    full_d  = (full_q | full_set) & ~full_clr;
    start_d = load && (beat_d == 3'd0);
    a_d     = load ? mem_q[{rd_bank_d, 1'b0, beat_d}] : 8'd0;
    b_d     = load ? mem_q[{rd_bank_d, 1'b1, ~beat_d}] : 8'd0;
    busy_d  = (full_d != 2'b00) || (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[{wr_bank_q, wr_cnt_q}] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= 4'd0;
      beat_q    <= 3'd0;
      full_q    <= 2'b00;
      gap_q     <= 8'd0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      a_q       <= 8'd0;
      b_q       <= 8'd0;
    end else begin
      state_q   <= state_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      beat_q    <= beat_d;
      full_q    <= full_d;
      gap_q     <= gap_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      a_q       <= a_d;
      b_q       <= b_d;
    end
  end

endmodule

// File: tb/tb_dct_input_feeder.sv
// Directed bench for dct_input_feeder: one instance with BLOCK_GAP=16, one with BLOCK_GAP=64.
module tb_dct_input_feeder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       va, vb;
  logic [7:0] da, db;
  logic       ra, sa, busya, rb, sb, busyb;
  logic [7:0] aa, ba, ab, bb;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [15:0] pa[$];
  logic [15:0] pb[$];
  int          sca[$];
  int          scb[$];
  bit          capt_a, capt_b;
  int          beat_a, beat_b;

  dct_input_feeder #(.BLOCK_GAP(16)) u_dut_a (
    .clk(clk), .reset(rst_n), .in_valid(va), .in_data(da), .in_ready(ra),
    .start(sa), .INPUT_A(aa), .INPUT_B(ba), .busy(busya)
  );

  dct_input_feeder #(.BLOCK_GAP(64)) u_dut_b (
    .clk(clk), .reset(rst_n), .in_valid(vb), .in_data(db), .in_ready(rb),
    .start(sb), .INPUT_A(ab), .INPUT_B(bb), .busy(busyb)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Pair capture: eight beats starting at each start pulse, with the cycle of each start.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      capt_a = 1'b0;
      capt_b = 1'b0;
    end else begin
      if (sa) begin capt_a = 1'b1; beat_a = 0; sca.push_back(cyc); end
      if (capt_a) begin
        pa.push_back({aa, ba});
        beat_a++;
        if (beat_a == 8) capt_a = 1'b0;
      end
      if (sb) begin capt_b = 1'b1; beat_b = 0; scb.push_back(cyc); end
      if (capt_b) begin
        pb.push_back({ab, bb});
        beat_b++;
        if (beat_b == 8) capt_b = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input bit sel_b, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!(sel_b ? busyb : busya)) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; va = 1'b0; vb = 1'b0; da = 8'd0; db = 8'd0;
    #2 rst_n = 1'b0;
    tick(); tick();
    n_tests++;
    if ({ra, sa, aa, ba, busya} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_a: got %h want %h", {ra, sa, aa, ba, busya}, 19'h40000);
    end
    n_tests++;
    if ({rb, sb, ab, bb, busyb} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_b: got %h want %h", {rb, sb, ab, bb, busyb}, 19'h40000);
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if ({ra, sa, busya} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_release: got %b want 100", {ra, sa, busya});
    end
  endtask

  task automatic test_single_block();
    logic [7:0]  x [16] = '{1, 3, 5, 7, 9, 17, 19, 21, 22, 18, 18, 16, 8, 6, 4, 2};
    logic [15:0] exp [8] = '{16'h0102, 16'h0304, 16'h0506, 16'h0708,
                             16'h0910, 16'h1112, 16'h1312, 16'h1516};
    logic [15:0] got;
    int c16, fall;
    pa.delete(); sca.delete();
    for (int i = 0; i < 16; i++) begin
      va = 1'b1; da = x[i];
      tick();
    end
    c16 = cyc; va = 1'b0; da = 8'd0;
    fall = -1;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (cyc == c16 + 9) begin
        n_tests++;
        if ({sa, aa, ba} !== 17'd0) begin
          n_fail++;
          $display("FAIL single_post_drain_zero: got %h want 0", {sa, aa, ba});
        end
      end
      if (fall < 0 && !busya) fall = cyc;
    end
    n_tests++;
    if (sca.size() != 1 || sca[0] != c16 + 1) begin
      n_fail++;
      $display("FAIL single_start: got %0d starts first at %0d want 1 at %0d",
               sca.size(), (sca.size() > 0) ? sca[0] : -1, c16 + 1);
    end
    for (int k = 0; k < 8; k++) begin
      got = (k < pa.size()) ? pa[k] : 16'hxxxx;
      n_tests++;
      if (got !== exp[k]) begin
        n_fail++;
        $display("FAIL single_pair[%0d]: got %h want %h", k, got, exp[k]);
      end
    end
    n_tests++;
    if (fall != c16 + 16) begin
      n_fail++;
      $display("FAIL single_busy_fall: got cycle %0d want %0d", fall, c16 + 16);
    end
  endtask

  task automatic test_continuous();
    logic [15:0] got, exp;
    int c16, lows;
    bit ok;
    pa.delete(); sca.delete();
    lows = 0; c16 = 0;
    for (int i = 0; i < 64; i++) begin
      if (ra !== 1'b1) lows++;
      va = 1'b1; da = 8'(i);
      tick();
      if (i == 15) c16 = cyc;
    end
    va = 1'b0;
    wait_idle(1'b0, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL cont_idle_timeout: got busy want idle"); end
    n_tests++;
    if (lows != 0) begin n_fail++; $display("FAIL cont_ready_low: got %0d low want 0", lows); end
    n_tests++;
    if (sca.size() != 4) begin
      n_fail++;
      $display("FAIL cont_start_count: got %0d want 4", sca.size());
    end
    for (int b = 0; b < 4 && b < sca.size(); b++) begin
      n_tests++;
      if (sca[b] != c16 + 1 + 16 * b) begin
        n_fail++;
        $display("FAIL cont_start[%0d]: got %0d want %0d", b, sca[b], c16 + 1 + 16 * b);
      end
    end
    got = (16 < pa.size()) ? pa[16] : 16'hxxxx;
    n_tests++;
    if (got !== 16'h202F) begin
      n_fail++;
      $display("FAIL cont_blk2_beat0: got %h want 202f", got);
    end
    for (int i = 0; i < 32; i++) begin
      exp = {8'(16 * (i / 8) + i % 8), 8'(16 * (i / 8) + 15 - i % 8)};
      got = (i < pa.size()) ? pa[i] : 16'hxxxx;
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL cont_pair[%0d]: got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] got, exp;
    int n_acc, c16, low_at, low_cyc, high_at;
    logic [7:0] idx;
    bit rdy, ok;
    pb.delete(); scb.delete();
    n_acc = 0; c16 = 0; low_at = -1; low_cyc = -1; high_at = -1; idx = 8'd0;
    for (int n = 0; n < 400 && n_acc < 64; n++) begin
      rdy = rb;
      vb  = 1'b1;
      db  = rdy ? idx : 8'hEE;
      tick();
      if (rdy) begin
        n_acc++; idx++;
        if (n_acc == 16) c16 = cyc;
      end
      if (low_at < 0 && !rb) begin low_at = n_acc; low_cyc = cyc; end
      if (low_at >= 0 && high_at < 0 && rb) high_at = cyc;
    end
    vb = 1'b0;
    wait_idle(1'b1, ok);
    n_tests++;
    if (!ok || n_acc != 64) begin
      n_fail++;
      $display("FAIL bp_timeout: got %0d accepts idle=%0d want 64 idle=1", n_acc, ok);
    end
    n_tests++;
    if (low_at != 48 || low_cyc != c16 + 32) begin
      n_fail++;
      $display("FAIL bp_ready_drop: got after %0d at %0d want after 48 at %0d",
               low_at, low_cyc, c16 + 32);
    end
    n_tests++;
    if (high_at != c16 + 73) begin
      n_fail++;
      $display("FAIL bp_ready_rise: got %0d want %0d", high_at, c16 + 73);
    end
    n_tests++;
    if (scb.size() != 4) begin
      n_fail++;
      $display("FAIL bp_start_count: got %0d want 4", scb.size());
    end
    for (int b = 0; b < 4 && b < scb.size(); b++) begin
      n_tests++;
      if (scb[b] != c16 + 1 + 64 * b) begin
        n_fail++;
        $display("FAIL bp_start[%0d]: got %0d want %0d", b, scb[b], c16 + 1 + 64 * b);
      end
    end
    for (int i = 0; i < 32; i++) begin
      exp = {8'(16 * (i / 8) + i % 8), 8'(16 * (i / 8) + 15 - i % 8)};
      got = (i < pb.size()) ? pb[i] : 16'hxxxx;
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL bp_pair[%0d]: got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_gapped();
    logic [7:0]  m [48];
    logic [15:0] got, exp;
    int n_acc;
    bit vld, rdy, ok;
    pa.delete(); sca.delete();
    for (int i = 0; i < 48; i++) m[i] = 8'($urandom_range(0, 255));
    n_acc = 0;
    for (int n = 0; n < 400 && n_acc < 48; n++) begin
      vld = 1'($urandom_range(0, 1));
      rdy = ra;
      va  = vld;
      da  = vld ? m[n_acc] : 8'($urandom_range(0, 255));
      tick();
      if (vld && rdy) n_acc++;
    end
    va = 1'b0;
    wait_idle(1'b0, ok);
    n_tests++;
    if (!ok || n_acc != 48 || sca.size() != 3) begin
      n_fail++;
      $display("FAIL gap_blocks: got %0d accepts %0d starts idle=%0d want 48 3 1",
               n_acc, sca.size(), ok);
    end
    for (int b = 1; b < 3 && b < sca.size(); b++) begin
      n_tests++;
      if (sca[b] - sca[b-1] < 16) begin
        n_fail++;
        $display("FAIL gap_spacing[%0d]: got %0d want >=16", b, sca[b] - sca[b-1]);
      end
    end
    for (int i = 0; i < 24; i++) begin
      exp = {m[16 * (i / 8) + i % 8], m[16 * (i / 8) + 15 - i % 8]};
      got = (i < pa.size()) ? pa[i] : 16'hxxxx;
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL gap_pair[%0d]: got %h want %h", i, got, exp);
      end
    end
  endtask

  // Feeds 16 samples base+i into instance A and checks for exactly one clean block.
  task automatic check_fresh_block(input string name, input int base);
    logic [15:0] got, exp;
    int c16;
    bit ok;
    pa.delete(); sca.delete();
    for (int i = 0; i < 16; i++) begin
      va = 1'b1; da = 8'(base + i);
      tick();
    end
    c16 = cyc; va = 1'b0;
    wait_idle(1'b0, ok);
    for (int n = 0; n < 20; n++) tick();
    n_tests++;
    if (!ok || sca.size() != 1 || sca[0] != c16 + 1) begin
      n_fail++;
      $display("FAIL %s_start: got %0d starts first at %0d idle=%0d want 1 at %0d", name,
               sca.size(), (sca.size() > 0) ? sca[0] : -1, ok, c16 + 1);
    end
    for (int k = 0; k < 8; k++) begin
      exp = {8'(base + k), 8'(base + 15 - k)};
      got = (k < pa.size()) ? pa[k] : 16'hxxxx;
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s_pair[%0d]: got %h want %h", name, k, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    int c16;
    for (int i = 0; i < 16; i++) begin
      va = 1'b1; da = 8'(100 + i);
      tick();
    end
    c16 = cyc; va = 1'b0;
    for (int n = 0; n < 10 && cyc < c16 + 4; n++) tick();
    n_tests++;
    if ({aa, ba} !== 16'h6770) begin
      n_fail++;
      $display("FAIL rst_drain_beat3: got %h want 6770", {aa, ba});
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({ra, sa, aa, ba, busya} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_drain_async: got %h want %h", {ra, sa, aa, ba, busya}, 19'h40000);
    end
    tick(); tick();
    rst_n = 1'b1;
    check_fresh_block("rst_drain", 200);
  endtask

  task automatic test_reset_mid_fill();
    for (int i = 0; i < 10; i++) begin
      va = 1'b1; da = 8'(50 + i);
      tick();
    end
    va = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_fresh_block("rst_fill", 150);
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_continuous();
    test_backpressure();
    test_gapped();
    test_reset_mid_drain();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
